// File: rtl/hazard_pkg.sv
// hazard_pkg: state encoding and pipeline control-bundle layout shared by the hazard controller and pipeline registers
package hazard_pkg;
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] ERROR    = 2'd2;
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
  } ctrl_t;
  localparam ctrl_t CTRL_HALT   = 7'b0000000;
  localparam ctrl_t CTRL_FREEZE = 7'b0000001;
  localparam ctrl_t CTRL_BRANCH = 7'b1111110;
  localparam ctrl_t CTRL_BUBBLE = 7'b0001110;
  localparam ctrl_t CTRL_RUN    = 7'b1101010;
endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// sat_counter: event counter that saturates at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for load-use, taken-branch and memory-wait hazards
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);
  localparam int WW = $clog2(TIMEOUT) + 1;
  logic [WW-1:0] wait_cnt;
  logic stall_mem, load_use;
  ctrl_t ctrl;
  assign stall_mem = mem_req & ~mem_ready;
  assign load_use = ex_mem_read & (ex_rd != '0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  always_comb
    ctrl = (!reset || state == ERROR) ? CTRL_HALT :
           (stall_mem && (state == RUN || state == MEM_WAIT)) ? CTRL_FREEZE :
           ex_branch_taken ? CTRL_BRANCH :
           load_use ? CTRL_BUBBLE : CTRL_RUN;
  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_write  = ctrl.id_ex_write;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_write = ctrl.ex_mem_write;
  assign mem_wb_flush = ctrl.mem_wb_flush;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state == RUN) begin
      if (stall_mem) begin
        state    <= MEM_WAIT;
        wait_cnt <= WW'(1);
      end
    end else if (state == MEM_WAIT) begin
      if (!stall_mem) begin
        state    <= RUN;
        wait_cnt <= '0;
      end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
        state       <= ERROR;
        mem_timeout <= 1'b1;
      end else wait_cnt <= wait_cnt + 1'b1;
    end else if (state != ERROR) begin
      state    <= RUN;
      wait_cnt <= '0;
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(clk), .reset(reset), .inc(state != ERROR && !ctrl.pc_write), .count(stall_count)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush (
    .clk(clk), .reset(reset), .inc(ctrl.if_id_flush), .count(flush_count)
  );
endmodule
